vrased_reset_ctrl: RTL and testbench
====================================

VRASED_RESET_CTRL -- requirements
Module: vrased_reset_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles sys_rst is held before memory clearing starts; legal range 1..255.
REQ-002 Parameter CLR_BASE, default 16'h0200: byte address of the first word cleared; must be even.
REQ-003 Parameter CLR_WORDS, default 1024: number of 16-bit words cleared; legal range 1..32768.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 viol  input  1  violation reset request from the vrased monitor, level-sensitive, synchronous to clk.
REQ-007 sys_rst  output  1  active-high reset to the MCU core.
REQ-008 clr_ram  output  1  high while the clear sweep runs; drives the monitor's clr_ram input.
REQ-009 mem_en  output  1  memory write-port enable.
REQ-010 mem_wr  output  1  memory write strobe.
REQ-011 mem_addr  output  16  memory byte address.
REQ-012 mem_din  output  16  write data; constant 16'h0000.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on completion of a sequence.
REQ-015 viol_cnt  output  8  count of viol-initiated sequences; saturates at 8'hFF.

Function
REQ-016 All outputs are registered; no output depends combinationally on viol.
REQ-017 The FSM has four states: IDLE, HOLD, CLEAR and RELEASE.
REQ-018 In IDLE, viol=1 sampled at edge t enters HOLD at t+1, with sys_rst=1 and busy=1 from t+1, and increments viol_cnt (saturating) at t+1.
REQ-019 HOLD lasts exactly HOLD_CYCLES cycles, then enters CLEAR.
REQ-020 While viol=1 in HOLD, the hold counter reloads to zero, so HOLD persists until HOLD_CYCLES cycles pass with viol=0.
REQ-021 Each CLEAR cycle i (i=0..CLR_WORDS-1) drives mem_en=1, mem_wr=1, mem_addr=CLR_BASE+2*i (mod 2^16) and clr_ram=1.
REQ-022 After the final CLEAR write, the FSM spends exactly one cycle in RELEASE, then enters IDLE.
REQ-023 In RELEASE: sys_rst=1, done=1, clr_ram=0, mem_en=0, mem_wr=0.
REQ-024 In IDLE: sys_rst=0, done=0, clr_ram=0, mem_en=0, mem_wr=0, mem_addr=16'h0000.
REQ-025 Outside CLEAR, mem_en=0, mem_wr=0 and clr_ram=0.
REQ-026 sys_rst=1 in HOLD, CLEAR and RELEASE.
REQ-027 viol=1 sampled in CLEAR or RELEASE aborts the sequence:
- next state HOLD, with the hold and word counters zeroed;
- viol_cnt incremented (saturating);
- done is not pulsed for the aborted sequence.
REQ-028 viol=1 sampled in HOLD does not increment viol_cnt.
REQ-029 The address increment wraps modulo 2^16 with no error indication.
REQ-030 Sequence length with viol low throughout = HOLD_CYCLES + CLR_WORDS + 1 cycles of sys_rst=1.

Reset
REQ-031 reset_n=0 asynchronously forces:
- state=HOLD, with hold and word counters 0;
- sys_rst=1, busy=1;
- clr_ram=0, mem_en=0, mem_wr=0, mem_addr=16'h0000, done=0;
- viol_cnt=8'h00.
REQ-032 After reset_n deasserts, a boot sequence (HOLD, CLEAR, RELEASE) runs without incrementing viol_cnt.
REQ-033 reset_n asserted mid-CLEAR abandons the sweep immediately; the boot sequence restarts from word 0 after deassertion.

Verification
Use HOLD_CYCLES=4, CLR_WORDS=8, CLR_BASE=16'h0200.
REQ-034 Boot: release reset_n, viol=0 ->
- sys_rst high for 13 cycles;
- 8 writes to 16'h0200..16'h020E, data 0;
- one done pulse, then IDLE;
- viol_cnt=0.
REQ-035 Idle violation: one-cycle viol pulse in IDLE ->
- sys_rst rises next cycle;
- clr_ram high for exactly 8 cycles;
- done pulses once;
- viol_cnt=1.
REQ-036 Mid-clear abort: viol pulse during the 4th CLEAR write ->
- HOLD next cycle;
- a full 8-word sweep restarts at 16'h0200;
- only one done pulse;
- viol_cnt=2.
REQ-037 Held violation: viol high for 20 cycles from IDLE ->
- HOLD persists throughout;
- CLEAR begins exactly 4 cycles after viol falls;
- viol_cnt increments by 1.
REQ-038 Async reset: reset_n low mid-CLEAR (off-clock-edge) ->
- mem_en=0 and sys_rst=1 immediately;
- viol_cnt=0;
- boot sweep restarts at 16'h0200.
REQ-039 Saturation: 260 separate idle violations -> viol_cnt=8'hFF, no wrap.

Source files
------------

// File: rtl/vrased_reset_ctrl.sv
`timescale 1ns/1ps
// Reset sequencer for a VRASED-protected MCU: holds the core in reset,
// sweeps a RAM region with zeros, then releases. Boots and violations share the sequence.
module vrased_reset_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [15:0] CLR_BASE    = 16'h0200,
    parameter int unsigned CLR_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        viol,
    output logic        sys_rst,
    output logic        clr_ram,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        busy,
    output logic        done,
    output logic [7:0]  viol_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_CLEAR   = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [14:0] WORD_LAST = 15'(CLR_WORDS - 1);

    logic [1:0]  state, nxt_state;
    logic [7:0]  hold_cnt, nxt_hold;
    logic [14:0] word_cnt, nxt_word;
    logic [7:0]  nxt_viol_cnt;
    logic [15:0] nxt_addr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign mem_din = 16'h0000;

    always_comb begin
        nxt_state    = state;
        nxt_hold     = hold_cnt;
        nxt_word     = word_cnt;
        nxt_viol_cnt = viol_cnt;
        // A violation restarts the sequence from any state; only HOLD absorbs it uncounted.
        if (viol && state != S_HOLD) begin
            nxt_state    = S_HOLD;
            nxt_hold     = 8'd0;
            nxt_word     = 15'd0;
            nxt_viol_cnt = sat_inc(viol_cnt);
        end else begin
            case (state)
                S_HOLD: begin
                    if (viol) begin
                        nxt_hold = 8'd0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        nxt_state = S_CLEAR;
                        nxt_hold  = 8'd0;
                        nxt_word  = 15'd0;
                    end else begin
                        nxt_hold = hold_cnt + 8'd1;
                    end
                end
                S_CLEAR: begin
                    if (word_cnt == WORD_LAST) begin
                        nxt_state = S_RELEASE;
                    end else begin
                        nxt_word = word_cnt + 15'd1;
                    end
                end
                S_RELEASE: nxt_state = S_IDLE;
                default:   nxt_state = S_IDLE;
            endcase
        end
    end

    assign nxt_addr = CLR_BASE + {nxt_word, 1'b0};

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_HOLD;
            hold_cnt <= 8'd0;
            word_cnt <= 15'd0;
            viol_cnt <= 8'h00;
            sys_rst  <= 1'b1;
            busy     <= 1'b1;
            clr_ram  <= 1'b0;
            mem_en   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= 16'h0000;
            done     <= 1'b0;
        end else begin
            state    <= nxt_state;
            hold_cnt <= nxt_hold;
            word_cnt <= nxt_word;
            viol_cnt <= nxt_viol_cnt;
            sys_rst  <= (nxt_state != S_IDLE);
            busy     <= (nxt_state != S_IDLE);
            clr_ram  <= (nxt_state == S_CLEAR);
            mem_en   <= (nxt_state == S_CLEAR);
            mem_wr   <= (nxt_state == S_CLEAR);
            mem_addr <= (nxt_state == S_CLEAR) ? nxt_addr : 16'h0000;
            done     <= (nxt_state == S_RELEASE);
        end
    end

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
`timescale 1ns/1ps
// Bench for vrased_reset_ctrl: table of idle-violation cycles, hand sequences for
// boot/abort/held/async-reset/saturation, and random viol/reset against a position model.
module tb_vrased_reset_ctrl;

    localparam int          H    = 4;
    localparam int          W    = 8;
    localparam logic [15:0] BASE = 16'h0200;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        viol;
    logic        sys_rst, clr_ram, mem_en, mem_wr, busy, done;
    logic [15:0] mem_addr, mem_din;
    logic [7:0]  viol_cnt;

    vrased_reset_ctrl #(.HOLD_CYCLES(H), .CLR_BASE(BASE), .CLR_WORDS(W)) dut (
        .clk(clk), .reset_n(reset_n), .viol(viol),
        .sys_rst(sys_rst), .clr_ram(clr_ram), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy), .done(done),
        .viol_cnt(viol_cnt)
    );

    always #5 clk = ~clk;

    logic [45:0] act;
    assign act = {sys_rst, busy, clr_ram, mem_en, mem_wr, done, mem_addr, mem_din, viol_cnt};

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        viol;
        logic        sr;
        logic        clr;
        logic        dn;
        logic [15:0] addr;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [14];

    int nsr, nwr, ndn, aok, n, nhold, ndn_pre;
    int mpos;
    int mcnt;
    logic rv, rr;

    function automatic logic [45:0] expv(input logic s, input logic c, input logic d,
                                         input logic [15:0] a, input logic [7:0] k);
        return {s, s, c, c, c, d, a, 16'h0000, k};
    endfunction

    // Model: one position index through the sequence, -1 when idle.
    function automatic logic [45:0] mexp();
        logic s, c, d;
        logic [15:0] a;
        s = (mpos >= 0);
        c = (mpos >= H) && (mpos < H + W);
        d = (mpos == H + W);
        a = c ? 16'(BASE + 2 * (mpos - H)) : 16'h0000;
        return expv(s, c, d, a, 8'(mcnt));
    endfunction

    task automatic model_step(input logic v, input logic r);
        if (!r) begin
            mpos = 0;
            mcnt = 0;
        end else if (v) begin
            if (mpos < 0 || mpos >= H) mcnt = (mcnt < 255) ? mcnt + 1 : 255;
            mpos = 0;
        end else if (mpos >= 0) begin
            mpos = mpos + 1;
            if (mpos > H + W) mpos = -1;
        end
    endtask

    task automatic chk(input string nm, input logic [45:0] a, input logic [45:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, a, e);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic wait_write(input logic [15:0] addr, input int budget, output int dn_seen);
        int k = 0;
        dn_seen = 0;
        while (!(mem_en === 1'b1 && mem_addr === addr) && k < budget) begin
            @(negedge clk);
            if (done === 1'b1) dn_seen++;
            k++;
        end
        if (!(mem_en === 1'b1 && mem_addr === addr)) begin
            total++;
            bad++;
            $display("FAIL write_timeout actual=%h required=%h", mem_addr, addr);
        end
    endtask

    task automatic run_seq(input int ncyc, output int n_sr, output int n_wr,
                           output int n_done, output int ok);
        n_sr = 0; n_wr = 0; n_done = 0; ok = 1;
        for (int k = 0; k <= ncyc; k++) begin
            if (k > 0) @(negedge clk);
            if (sys_rst === 1'b1) n_sr++;
            if (done === 1'b1) n_done++;
            if (mem_en === 1'b1 && mem_wr === 1'b1) begin
                if (mem_addr !== 16'(BASE + 2 * n_wr) || mem_din !== 16'h0000 || clr_ram !== 1'b1)
                    ok = 0;
                n_wr++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle violation, cycle by cycle: hold 4, clear 8, release 1, idle.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd1};
        for (int k = 1; k < 4; k++)  tbl[k] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd1};
        for (int k = 4; k < 12; k++) tbl[k] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'(BASE + 2 * (k - 4)), 8'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'd1};

        viol = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", act, expv(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00));
        viol = 1'b1;
        @(negedge clk);
        chk("reset_ignores_viol", act, expv(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00));
        viol = 1'b0;

        // Boot
        reset_n = 1'b1;
        #1;
        run_seq(20, nsr, nwr, ndn, aok);
        chk_int("boot_sys_rst_cycles", nsr, H + W + 1);
        chk_int("boot_writes", nwr, W);
        chk_int("boot_addr_seq", aok, 1);
        chk_int("boot_done_pulses", ndn, 1);
        chk("boot_idle", act, expv(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00));

        // Idle violation table
        for (int k = 0; k < 14; k++) begin
            viol = tbl[k].viol;
            @(negedge clk);
            chk($sformatf("tbl%0d", k), act,
                expv(tbl[k].sr, tbl[k].clr, tbl[k].dn, tbl[k].addr, tbl[k].cnt));
        end
        viol = 1'b0;

        // Mid-clear abort, starting from a fresh boot
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wait_idle(40);
        viol = 1'b1;
        @(negedge clk);
        viol = 1'b0;
        wait_write(BASE + 16'd6, 30, ndn_pre);
        viol = 1'b1;
        @(negedge clk);
        viol = 1'b0;
        chk("abort_hold", act, expv(1'b1, 1'b0, 1'b0, 16'h0000, 8'd2));
        run_seq(20, nsr, nwr, ndn, aok);
        chk_int("abort_sys_rst_cycles", nsr, H + W + 1);
        chk_int("abort_writes", nwr, W);
        chk_int("abort_addr_seq", aok, 1);
        chk_int("abort_done_pulses", ndn + ndn_pre, 1);
        chk("abort_idle", act, expv(1'b0, 1'b0, 1'b0, 16'h0000, 8'd2));

        // Held violation for 20 cycles
        nhold = 0;
        viol = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sys_rst === 1'b1 && busy === 1'b1 && clr_ram === 1'b0 && done === 1'b0) nhold++;
        end
        viol = 1'b0;
        chk_int("held_hold_cycles", nhold, 20);
        n = 0;
        while (clr_ram !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk_int("held_clear_delay", n, H);
        chk("held_first_write", act, expv(1'b1, 1'b1, 1'b0, BASE, 8'd3));
        wait_idle(30);

        // Asynchronous reset in the middle of a sweep
        viol = 1'b1;
        @(negedge clk);
        viol = 1'b0;
        wait_write(BASE + 16'd4, 30, ndn_pre);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", act, expv(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        run_seq(20, nsr, nwr, ndn, aok);
        chk_int("reboot_writes", nwr, W);
        chk_int("reboot_addr_seq", aok, 1);
        chk_int("reboot_done_pulses", ndn, 1);
        chk("reboot_idle", act, expv(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00));

        // Saturation over 260 idle violations
        for (int i = 1; i <= 260; i++) begin
            viol = 1'b1;
            @(negedge clk);
            viol = 1'b0;
            wait_idle(30);
            if (i == 254) chk_int("sat_254", int'(viol_cnt), 254);
            if (i == 255) chk_int("sat_255", int'(viol_cnt), 255);
        end
        chk_int("sat_260", int'(viol_cnt), 255);

        // Random viol and reset against the model
        reset_n = 1'b0;
        @(negedge clk);
        mpos = 0;
        mcnt = 0;
        chk("rand_reset", act, mexp());
        reset_n = 1'b1;
        for (int c = 0; c < 800; c++) begin
            rv = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 199) != 0);
            viol = rv;
            reset_n = rr;
            if (!rr) begin
                #1;
                model_step(rv, rr);
                chk($sformatf("rand_async_c%0d", c), act, mexp());
            end
            @(negedge clk);
            model_step(rv, rr);
            chk($sformatf("rand_c%0d", c), act, mexp());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
